spike_window_monitor: RTL

- Downstream consumer of the LIF neuron's 1-bit spike output.
- Divides time into fixed windows of WINDOW enabled cycles. For each window it counts spikes and records the offset of the first spike.
- Each closed window's record is pushed into a small FIFO, drained over a valid/ready interface by the readout/IO logic.
- Records that cannot be stored are dropped and flagged; nothing ever back-pressures the neuron.

---
 rtl/spike_window_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spike_window_monitor.sv
// spike_window_monitor
//   Splits time into windows of WINDOW enabled cycles. For each window it
//   counts spikes (saturating) and records the offset of the first spike.
//   Each closed window is pushed into a DEPTH-entry FIFO drained over a
//   valid/ready interface. The neuron is never back-pressured: a record that
//   finds the FIFO full is dropped and drop_o is set (sticky).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   en_i         window advance enable; low freezes window and spike sampling
//   spike_i      spike input, sampled only when en_i=1
//   clr_i        synchronous clear: restart window, flush FIFO, clear drop_o
//   rec_valid_o  FIFO non-empty
//   rec_ready_i  consumer accepts head record
//   rec_count_o  spike count of head record (0 when empty)
//   rec_first_o  first-spike offset of head record (0 when empty)
//   drop_o       sticky: a record was discarded because the FIFO was full
//   fill_o       FIFO occupancy
module spike_window_monitor #(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       spike_i,
  input  logic                       clr_i,
  output logic                       rec_valid_o,
  input  logic                       rec_ready_i,
  output logic [CNT_W-1:0]           rec_count_o,
  output logic [7:0]                 rec_first_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0]       LastOff = 8'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [AW:0]      PtrOne  = (AW + 1)'(1);

  // Window accumulation state
  logic [7:0]       r_offset;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_first;
  logic             r_seen;
  logic             r_drop;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [CNT_W-1:0] r_mem_count [DEPTH];
  logic [7:0]       r_mem_first [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic             w_spike;
  logic             w_close;
  logic [CNT_W-1:0] w_rec_count;
  logic [7:0]       w_rec_first;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  always_comb begin
    w_spike = en_i & spike_i;
    w_close = en_i && (r_offset == LastOff);

    // Record values include the spike sampled on the closing edge itself
    w_rec_count = r_count;
    if (w_spike && (r_count != CntMax)) begin
      w_rec_count = r_count + CntOne;
    end
    w_rec_first = r_first;
    if (w_spike && !r_seen) begin
      w_rec_first = r_offset;
    end

    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = !clr_i && !w_empty && rec_ready_i;
    // A pop on the same edge frees the slot the push needs
    w_push  = !clr_i && w_close && (!w_full || w_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_offset <= '0;
      r_count  <= '0;
      r_first  <= '0;
      r_seen   <= 1'b0;
      r_drop   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr_i) begin
      r_offset <= '0;
      r_count  <= '0;
      r_first  <= '0;
      r_seen   <= 1'b0;
      r_drop   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (en_i) begin
        if (w_close) begin
          r_offset <= '0;
          r_count  <= '0;
          r_first  <= '0;
          r_seen   <= 1'b0;
        end else begin
          r_offset <= r_offset + 8'd1;
          if (spike_i) begin
            r_count <= w_rec_count;
            r_first <= w_rec_first;
            r_seen  <= 1'b1;
          end
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      if (w_close && !w_push) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_count[r_wr_ptr[AW-1:0]] <= w_rec_count;
      r_mem_first[r_wr_ptr[AW-1:0]] <= w_rec_first;
    end
  end

  always_comb begin
    rec_valid_o = !w_empty;
    rec_count_o = '0;
    rec_first_o = '0;
    if (!w_empty) begin
      rec_count_o = r_mem_count[r_rd_ptr[AW-1:0]];
      rec_first_o = r_mem_first[r_rd_ptr[AW-1:0]];
    end
    drop_o = r_drop;
    fill_o = r_wr_ptr - r_rd_ptr;
  end

endmodule
